// File: rtl/gmii_pix_pack.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_pix_pack
//  Description : Packs a YUV422 pixel stream into one 48-bit word per pixel,
//                tagged with line and column, for the async GMII TX FIFO.
//                Every forwarded line is written as one contiguous burst of
//                exactly H_ACTIVE words. Short lines are zero-padded and long
//                lines are truncated. Lines that cannot be forwarded are
//                dropped and counted.
//  Ports       : fifo_clk   - pixel clock / FIFO write clock
//                sys_rst    - synchronous active-high reset
//                vsync, de  - video timing (vsync polarity = VS_POL)
//                pix_y/pix_c- luma / alternating Cb,Cr
//                enable     - gate for starting new lines
//                fifo_full  - TX FIFO full
//                fifo_din   - {line,col,pix_c,pix_y,8'h00}
//                fifo_wr_en - FIFO write strobe (falling edge = line ready)
//                ovf_err    - sticky, write suppressed by fifo_full mid-line
//                len_err    - sticky, DE length differed from H_ACTIVE
//                drop_cnt   - saturating count of skipped/aborted lines
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_pix_pack #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   V_ACTIVE   = 720,
    parameter logic VS_POL     = 1'b1,
    parameter int   LINE_DECIM = 1
) (
    input  logic        fifo_clk,
    input  logic        sys_rst,
    input  logic        vsync,
    input  logic        de,
    input  logic [7:0]  pix_y,
    input  logic [7:0]  pix_c,
    input  logic        enable,
    input  logic        fifo_full,
    output logic [47:0] fifo_din,
    output logic        fifo_wr_en,
    output logic        ovf_err,
    output logic        len_err,
    output logic [15:0] drop_cnt
);

    localparam logic [2:0] c_st_nosync   = 3'd0;
    localparam logic [2:0] c_st_wait_de  = 3'd1;
    localparam logic [2:0] c_st_active   = 3'd2;
    localparam logic [2:0] c_st_pad      = 3'd3;
    localparam logic [2:0] c_st_trunc    = 3'd4;
    localparam logic [2:0] c_st_skip     = 3'd5;
    localparam logic [2:0] c_st_line_end = 3'd6;

    localparam logic [11:0] c_h_last     = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_v_active   = 12'(V_ACTIVE);
    localparam logic [3:0]  c_decim_last = 4'(LINE_DECIM - 1);

    logic        r_vs, r_vs_d, r_de, r_de_d;
    logic [7:0]  r_py, r_pc;
    logic [2:0]  r_state;
    logic [11:0] r_line, r_col;
    logic [3:0]  r_decim;
    logic        r_vs_pend;

    logic w_vs_rise, w_de_rise;

    assign w_vs_rise = (r_vs == VS_POL) && (r_vs_d != VS_POL);
    assign w_de_rise = r_de && !r_de_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge fifo_clk) begin
        if (sys_rst) begin
            r_vs       <= ~VS_POL;
            r_vs_d     <= ~VS_POL;
            r_de       <= 1'b0;
            r_de_d     <= 1'b0;
            r_py       <= 8'h00;
            r_pc       <= 8'h00;
            r_state    <= c_st_nosync;
            r_line     <= 12'd0;
            r_col      <= 12'd0;
            r_decim    <= 4'd0;
            r_vs_pend  <= 1'b0;
            fifo_din   <= 48'h0;
            fifo_wr_en <= 1'b0;
            ovf_err    <= 1'b0;
            len_err    <= 1'b0;
            drop_cnt   <= 16'h0;
        end else begin
            r_vs       <= vsync;
            r_vs_d     <= r_vs;
            r_de       <= de;
            r_de_d     <= r_de;
            r_py       <= pix_y;
            r_pc       <= pix_c;
            fifo_wr_en <= 1'b0;

            case (r_state)
                c_st_nosync: begin
                    if (w_vs_rise) begin
                        r_line    <= 12'd0;
                        r_decim   <= 4'd0;
                        r_vs_pend <= 1'b0;
                        r_state   <= c_st_wait_de;
                    end
                end

                c_st_wait_de: begin
                    if (w_vs_rise) begin
                        r_line  <= 12'd0;
                        r_decim <= 4'd0;
                    end else if (w_de_rise && (r_line < c_v_active)) begin
                        if ((r_decim != 4'd0) || !enable || fifo_full) begin
                            r_state <= c_st_skip;
                            // Decimated lines are intentional, not drops.
                            if (r_decim == 4'd0)
                                drop_cnt <= sat_inc16(drop_cnt);
                        end else begin
                            fifo_wr_en <= 1'b1;
                            fifo_din   <= {r_line, 12'd0, r_pc, r_py, 8'h00};
                            r_col      <= 12'd1;
                            r_state    <= (c_h_last == 12'd0) ? c_st_trunc : c_st_active;
                        end
                    end
                end

                c_st_active, c_st_pad: begin
                    // Frame restart must not split a burst: hold it until line end.
                    if (w_vs_rise)
                        r_vs_pend <= 1'b1;
                    // A new DE while still padding cannot be forwarded.
                    if ((r_state == c_st_pad) && w_de_rise)
                        drop_cnt <= sat_inc16(drop_cnt);
                    if (fifo_full) begin
                        ovf_err  <= 1'b1;
                        drop_cnt <= sat_inc16(drop_cnt);
                        r_state  <= r_de ? c_st_skip : c_st_line_end;
                    end else begin
                        fifo_wr_en <= 1'b1;
                        if ((r_state == c_st_active) && r_de) begin
                            fifo_din <= {r_line, r_col, r_pc, r_py, 8'h00};
                        end else begin
                            // Padding starts on the very cycle DE drops so the
                            // burst stays unbroken.
                            fifo_din <= {r_line, r_col, 24'h0};
                            if (r_state == c_st_active)
                                len_err <= 1'b1;
                        end
                        if (r_col == c_h_last) begin
                            r_state <= ((r_state == c_st_active) && r_de) ? c_st_trunc
                                                                          : c_st_line_end;
                        end else begin
                            r_col <= r_col + 12'd1;
                            if (!r_de)
                                r_state <= c_st_pad;
                        end
                    end
                end

                c_st_trunc, c_st_skip: begin
                    if ((r_state == c_st_trunc) && r_de)
                        len_err <= 1'b1;
                    if (w_vs_rise) begin
                        r_line    <= 12'd0;
                        r_decim   <= 4'd0;
                        r_vs_pend <= 1'b0;
                        r_state   <= c_st_wait_de;
                    end else if (!r_de) begin
                        r_state <= c_st_line_end;
                    end
                end

                c_st_line_end: begin
                    if (r_vs_pend || w_vs_rise) begin
                        r_line  <= 12'd0;
                        r_decim <= 4'd0;
                    end else begin
                        r_line  <= (r_line == 12'hFFF) ? r_line : r_line + 12'd1;
                        r_decim <= (r_decim == c_decim_last) ? 4'd0 : r_decim + 4'd1;
                    end
                    r_vs_pend <= 1'b0;
                    r_state   <= c_st_wait_de;
                end

                default: r_state <= c_st_nosync;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_pix_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_pix_pack
//  Description : Self-checking bench for gmii_pix_pack. Three instances:
//                u_a full 1280-wide format, u_b narrow lines for frame-height
//                and deferred-vsync cases, u_c narrow lines with LINE_DECIM=2.
//                A line-level model predicts every FIFO word, burst length
//                and status flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_pix_pack;

    localparam int H_OF [3] = '{1280, 8, 8};
    localparam int V_OF [3] = '{720, 720, 720};
    localparam int D_OF [3] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_i [3];
    logic        de_i [3];
    logic        en_i [3];
    logic        full_i [3];
    logic [7:0]  py_i [3];
    logic [7:0]  pc_i [3];
    logic [47:0] din_o [3];
    logic        wr_o [3];
    logic        ovf_o [3];
    logic        len_o [3];
    logic [15:0] drop_o [3];

    always #5 clk = ~clk;

    gmii_pix_pack u_a (
        .fifo_clk(clk), .sys_rst(rst), .vsync(vs_i[0]), .de(de_i[0]),
        .pix_y(py_i[0]), .pix_c(pc_i[0]), .enable(en_i[0]), .fifo_full(full_i[0]),
        .fifo_din(din_o[0]), .fifo_wr_en(wr_o[0]), .ovf_err(ovf_o[0]),
        .len_err(len_o[0]), .drop_cnt(drop_o[0]));

    gmii_pix_pack #(.H_ACTIVE(8)) u_b (
        .fifo_clk(clk), .sys_rst(rst), .vsync(vs_i[1]), .de(de_i[1]),
        .pix_y(py_i[1]), .pix_c(pc_i[1]), .enable(en_i[1]), .fifo_full(full_i[1]),
        .fifo_din(din_o[1]), .fifo_wr_en(wr_o[1]), .ovf_err(ovf_o[1]),
        .len_err(len_o[1]), .drop_cnt(drop_o[1]));

    gmii_pix_pack #(.H_ACTIVE(8), .LINE_DECIM(2)) u_c (
        .fifo_clk(clk), .sys_rst(rst), .vsync(vs_i[2]), .de(de_i[2]),
        .pix_y(py_i[2]), .pix_c(pc_i[2]), .enable(en_i[2]), .fifo_full(full_i[2]),
        .fifo_din(din_o[2]), .fifo_wr_en(wr_o[2]), .ovf_err(ovf_o[2]),
        .len_err(len_o[2]), .drop_cnt(drop_o[2]));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { int id; logic [47:0] w; } word_t;
    typedef struct { int id; int n; } burst_t;
    word_t  wq[$];
    burst_t bq[$];

    int m_line [3], m_decim [3], m_drop [3];
    bit m_ovf [3], m_len [3], m_sync [3];
    int seed_ctr = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_line[i] = 0; m_decim[i] = 0; m_drop[i] = 0;
            m_ovf[i] = 0; m_len[i] = 0; m_sync[i] = 0;
        end
    endtask

    // fmode: 0 none, 1 FIFO full for the whole line, 2 full at write of fcol
    task automatic model_line(input int id, input int len, input int fmode, input int fcol,
                              input bit en, input bit vs_mid, input logic [7:0] s);
        int n;
        word_t e;
        if (!m_sync[id] || m_line[id] >= V_OF[id]) return;
        if (m_decim[id] != 0) begin
        end else if (!en || fmode == 1) begin
            m_drop[id]++;
        end else begin
            n = 0;
            for (int c = 0; c < H_OF[id]; c++) begin
                if (fmode == 2 && c == fcol) begin
                    m_ovf[id] = 1;
                    m_drop[id]++;
                    break;
                end
                e.id = id;
                if (c < len) e.w = {12'(m_line[id]), 12'(c), 8'hA5 ^ s, 8'(c) + s, 8'h00};
                else         e.w = {12'(m_line[id]), 12'(c), 24'h0};
                wq.push_back(e);
                n++;
            end
            if (n > 0) bq.push_back('{id, n});
            if (len != H_OF[id]) m_len[id] = 1;
        end
        if (vs_mid) begin
            m_line[id] = 0; m_decim[id] = 0;
        end else begin
            if (m_line[id] < 4095) m_line[id]++;
            m_decim[id] = (m_decim[id] == D_OF[id] - 1) ? 0 : m_decim[id] + 1;
        end
    endtask

    // ---------------- compare process ----------------
    int          run [3] = '{0, 0, 0};
    int          wcount [3] = '{0, 0, 0};
    logic [47:0] first_w [3], last_w [3];
    word_t       ce;
    burst_t      cb;

    always @(negedge clk) begin
        if (!rst) begin
            for (int id = 0; id < 3; id++) begin
                if (wr_o[id]) begin
                    if (run[id] == 0) first_w[id] = din_o[id];
                    last_w[id] = din_o[id];
                    run[id]++;
                    wcount[id]++;
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write dut%0d: actual=%0h required=none", id, din_o[id]);
                    end else begin
                        ce = wq.pop_front();
                        check($sformatf("word_owner dut%0d", id), 64'(id), 64'(ce.id));
                        check($sformatf("word dut%0d", id), 64'(din_o[id]), 64'(ce.w));
                    end
                end else if (run[id] > 0) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_burst dut%0d: actual=%0d required=none", id, run[id]);
                    end else begin
                        cb = bq.pop_front();
                        check($sformatf("burst_owner dut%0d", id), 64'(id), 64'(cb.id));
                        check($sformatf("burst_len dut%0d", id), 64'(run[id]), 64'(cb.n));
                    end
                    run[id] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_flags(input int id);
        check($sformatf("ovf_err dut%0d", id), 64'(ovf_o[id]), 64'(m_ovf[id]));
        check($sformatf("len_err dut%0d", id), 64'(len_o[id]), 64'(m_len[id]));
        check($sformatf("drop_cnt dut%0d", id), 64'(drop_o[id]), 64'(m_drop[id]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check($sformatf("rst_din dut%0d", id), 64'(din_o[id]), 64'h0);
            check($sformatf("rst_wr dut%0d", id), 64'(wr_o[id]), 64'h0);
        end
        model_reset();
        for (int id = 0; id < 3; id++) check_flags(id);
        rst = 1'b0;
    endtask

    task automatic vs_pulse(input int id);
        @(negedge clk); vs_i[id] = 1'b1;
        @(negedge clk);
        @(negedge clk); vs_i[id] = 1'b0;
        repeat (4) @(negedge clk);
        m_sync[id] = 1; m_line[id] = 0; m_decim[id] = 0;
    endtask

    task automatic send_line(input int id, input int len, input int fmode, input int fcol,
                             input bit en, input int vcol);
        logic [7:0] s;
        int gap;
        s = 8'(seed_ctr);
        seed_ctr++;
        model_line(id, len, fmode, fcol, en, vcol >= 0, s);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            de_i[id]   = 1'b1;
            py_i[id]   = 8'(i) + s;
            pc_i[id]   = 8'hA5 ^ s;
            en_i[id]   = en;
            vs_i[id]   = (vcol >= 0) && (i == vcol || i == vcol + 1);
            full_i[id] = (fmode == 1) || (fmode == 2 && i == fcol + 1);
        end
        @(negedge clk);
        de_i[id] = 1'b0; vs_i[id] = 1'b0; full_i[id] = 1'b0; en_i[id] = 1'b1;
        gap = ((H_OF[id] > len) ? H_OF[id] - len : 0) + 8;
        repeat (gap) @(negedge clk);
        check_flags(id);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vs_i[i] = 1'b0; de_i[i] = 1'b0; en_i[i] = 1'b1; full_i[i] = 1'b0;
            py_i[i] = 8'h00; pc_i[i] = 8'h00;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check($sformatf("reset_din dut%0d", id), 64'(din_o[id]), 64'h0);
            check($sformatf("reset_wr dut%0d", id), 64'(wr_o[id]), 64'h0);
            check_flags(id);
        end
        rst = 1'b0;

        // Full-length line, then a short line.
        vs_pulse(0);
        send_line(0, 1280, 0, 0, 1'b1, -1);
        check("first_word", 64'(first_w[0]), 64'h0000_00A5_0000);
        check("last_word", 64'(last_w[0]), 64'h0004_FFA5_FF00);
        check("full_line_writes", 64'(wcount[0]), 64'd1280);
        check("no_len_err", 64'(len_o[0]), 64'd0);
        send_line(0, 1000, 0, 0, 1'b1, -1);
        check("short_len_err", 64'(len_o[0]), 64'd1);
        check("short_writes", 64'(wcount[0]), 64'd2560);
        check("short_pad_last", 64'(last_w[0]), 64'h0014_FF00_0000);

        // Long line truncates; following line is line 1.
        do_reset();
        vs_pulse(0);
        send_line(0, 1300, 0, 0, 1'b1, -1);
        check("long_len_err", 64'(len_o[0]), 64'd1);
        send_line(0, 1280, 0, 0, 1'b1, -1);
        check("after_long_line_tag", 64'(first_w[0][47:36]), 64'd1);

        // FIFO full at line start.
        do_reset();
        vs_pulse(0);
        base = wcount[0];
        send_line(0, 1280, 1, 0, 1'b1, -1);
        check("full_start_writes", 64'(wcount[0] - base), 64'd0);
        check("full_start_drop", 64'(drop_o[0]), 64'd1);

        // FIFO full at column 500, then recovery, then enable low.
        do_reset();
        vs_pulse(0);
        send_line(0, 1280, 0, 0, 1'b1, -1);
        base = wcount[0];
        send_line(0, 1280, 2, 500, 1'b1, -1);
        check("abort_writes", 64'(wcount[0] - base), 64'd500);
        check("abort_ovf", 64'(ovf_o[0]), 64'd1);
        check("abort_drop", 64'(drop_o[0]), 64'd1);
        base = wcount[0];
        send_line(0, 1280, 0, 0, 1'b1, -1);
        check("resume_writes", 64'(wcount[0] - base), 64'd1280);
        check("resume_tag", 64'(first_w[0][47:36]), 64'd2);
        send_line(0, 1280, 0, 0, 1'b0, -1);
        check("disabled_drop", 64'(drop_o[0]), 64'd2);

        // Frame height limit, then deferred mid-line vsync.
        vs_pulse(1);
        for (int n = 0; n < 722; n++) send_line(1, 8, 0, 0, 1'b1, -1);
        check("frame_writes", 64'(wcount[1]), 64'd5760);
        check("frame_last_tag", 64'(last_w[1][47:36]), 64'd719);
        vs_pulse(1);
        send_line(1, 8, 0, 0, 1'b1, -1);
        send_line(1, 8, 0, 0, 1'b1, -1);
        send_line(1, 8, 0, 0, 1'b1, 3);
        check("vs_mid_line_tag", 64'(last_w[1][47:24]), 64'h002_007);
        send_line(1, 8, 0, 0, 1'b1, -1);
        check("new_frame_tag", 64'(first_w[1][47:24]), 64'h000_000);

        // Line decimation by 2.
        vs_pulse(2);
        for (int n = 0; n < 4; n++) send_line(2, 8, 0, 0, 1'b1, -1);
        check("decim_writes", 64'(wcount[2]), 64'd16);
        check("decim_last_tag", 64'(last_w[2][47:36]), 64'd2);
        check("decim_drop", 64'(drop_o[2]), 64'd0);

        repeat (4) @(negedge clk);
        check("leftover_words", 64'(wq.size()), 64'd0);
        check("leftover_bursts", 64'(bq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
